// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: operation codes and FSM states shared by the multiply/divide unit
package muldiv_unit_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_t;
endpackage

// File: rtl/muldiv_unit_div_step.sv
// muldiv_unit_div_step: one restoring-division step, valid while rem < divisor
module muldiv_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             din,
  output logic [WIDTH-1:0] rem_next,
  output logic             q
);
  logic [WIDTH:0] sh, diff;
  assign sh       = {rem, din};
  assign diff     = sh - {1'b0, divisor};
  assign q        = !diff[WIDTH];
  assign rem_next = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide owning HI/LO; define MULDIV_FAST_MUL_EN for single-cycle multiply
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic               neg_p, neg_r, dz, accept, sgn_a, sgn_b, is_mul, is_div, is_mt, last, qb, mul_fin;
  logic [WIDTH-1:0]   mc, mag_a, mag_b, rem_n, quo, rem, dz_hi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p, mul_next, div_next, mul_res, mul_fix;
  assign req_ready = state == ST_IDLE && !flush;
  assign busy      = state != ST_IDLE;
  assign accept    = req_valid && req_ready;
  assign is_mul    = req_op == OP_MULT || req_op == OP_MULTU;
  assign is_div    = req_op == OP_DIV || req_op == OP_DIVU;
  assign is_mt     = req_op == OP_MTHI || req_op == OP_MTLO;
  assign sgn_a     = (req_op == OP_MULT || req_op == OP_DIV) && req_a[WIDTH-1];
  assign sgn_b     = (req_op == OP_MULT || req_op == OP_DIV) && req_b[WIDTH-1];
  assign mag_a     = sgn_a ? -req_a : req_a;
  assign mag_b     = sgn_b ? -req_b : req_b;
  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign sum       = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
  assign mul_next  = {sum, p[WIDTH-1:1]};
  muldiv_unit_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (p[2*WIDTH-1:WIDTH]),
    .divisor  (mc),
    .din      (p[WIDTH-1]),
    .rem_next (rem_n),
    .q        (qb)
  );
  assign div_next  = {rem_n, p[WIDTH-2:0], qb};
  assign last      = cnt == CW'(WIDTH - 1);
`ifdef MULDIV_FAST_MUL_EN
  assign mul_res   = (2*WIDTH)'(mc) * (2*WIDTH)'(p[WIDTH-1:0]);
  assign mul_fin   = 1'b1;
`else
  assign mul_res   = mul_next;
  assign mul_fin   = last;
`endif
  assign mul_fix   = neg_p ? -mul_res : mul_res;
  assign quo       = neg_p ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem       = neg_r ? -rem_n : rem_n;
  assign dz_hi     = neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      p     <= '0;
      mc    <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          cnt   <= '0;
          neg_p <= sgn_a ^ sgn_b;
          neg_r <= sgn_a;
          dz    <= req_b == '0;
          mc    <= mag_b;
          p     <= {{WIDTH{1'b0}}, mag_a};
          state <= is_mul ? ST_MUL : is_div ? ST_DIV : ST_IDLE;
          done  <= is_mt;
          if (req_op == OP_MTHI) hi <= req_a;
          if (req_op == OP_MTLO) lo <= req_a;
        end
      end else if (flush) begin
        state <= ST_IDLE;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == ST_MUL) begin
          p <= mul_next;
          if (mul_fin) begin
            {hi, lo} <= mul_fix;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end else begin
          p <= div_next;
          if (dz || last) begin
            {hi, lo} <= dz ? {dz_hi, {WIDTH{1'b1}}} : {rem, quo};
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W;
`endif
  logic         clk = 0, rst = 1, req_valid = 0, flush = 0;
  logic [2:0]   req_op = 0;
  logic [W-1:0] req_a = 0, req_b = 0;
  logic         req_ready, busy, done;
  logic [W-1:0] hi, lo;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    string        name;
  } exp_t;
  exp_t         sbq[$];
  logic [W-1:0] m_hi = 0, m_lo = 0;
  int           cyc = 0, checks = 0, errors = 0;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, b,
                       output logic [W-1:0] nh, nl, output int lat);
    longint sa, sv;
    logic [63:0] pr;
    nh = m_hi;
    nl = m_lo;
    lat = 0;
    sa = longint'($signed(a));
    sv = longint'($signed(b));
    case (op)
      3'd0: begin pr = sa * sv; {nh, nl} = pr; lat = MUL_LAT; end
      3'd1: begin pr = {32'd0, a} * {32'd0, b}; {nh, nl} = pr; lat = MUL_LAT; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          nh = a;
          nl = '1;
          lat = 1;
        end else if (op == 3'd2) begin
          nl = 32'(sa / sv);
          nh = 32'(sa % sv);
          lat = W;
        end else begin
          nl = a / b;
          nh = a % b;
          lat = W;
        end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input bit push, input string n);
    int w;
    int lat;
    exp_t e;
    logic [W-1:0] nh, nl;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout %s: req_ready got 0 expected 1", n);
    end
    req_valid = 1;
    req_op = op;
    req_a = a;
    req_b = b;
    if (push && op <= 3'd5) begin
      model(op, a, b, nh, nl, lat);
      m_hi = nh;
      m_lo = nl;
      e.hi = nh;
      e.lo = nl;
      e.cyc = cyc + 1 + lat;
      e.name = n;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done got 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_ready"}, req_ready, !flush);
      end
    end
  end
  function automatic logic [W-1:0] pick(input int zero_bias);
    int s;
    s = $urandom_range(0, 9);
    return s < zero_bias ? '0 : s == 3 ? 32'h8000_0000 : s == 4 ? '1 : s == 5 ? 32'(7) : W'($urandom);
  endfunction
  initial begin
    int w;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", req_ready, 1);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1, "mult");
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1, "multu");
    issue(3'd2, -32'sd7, 32'd2, 1, "div");
    issue(3'd3, 32'h1234, 32'd0, 1, "divu_zero");
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
    issue(3'd2, 32'd100, 32'd7, 0, "div_flushed");
    repeat (10) @(negedge clk);
    chk("busy_before_flush", busy, 1);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    flush = 1;
    req_valid = 1;
    req_op = 3'd4;
    req_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 0;
    flush = 0;
    @(negedge clk);
    chk("flush_mthi_hi", hi, m_hi);
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1, "mtlo");
    issue(3'd4, 32'h0BAD_F00D, 32'd0, 1, "mthi");
    issue(3'd6, 32'h1111_1111, 32'd3, 1, "op6");
    issue(3'd7, 32'h2222_2222, 32'd3, 1, "op7");
    issue(3'd4, 32'h5555_AAAA, 32'd0, 1, "mthi_b2b");
    for (int i = 0; i < 50; i++) issue(3'($urandom_range(0, 7)), pick(1), pick(2), 1, "rand");
    w = 0;
    while (sbq.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", sbq.size(), 0);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, "mult_reset");
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_hi = 0;
    m_lo = 0;
    chk("midreset_hi", hi, m_hi);
    chk("midreset_lo", lo, m_lo);
    chk("midreset_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("midreset_done", done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit owning the architectural HI/LO registers, parametrised in operand width. It sits in the execute stage beside the single-cycle functional unit. The issue logic hands it MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake, and the unit stalls further issue while busy. It supports pipeline flush on branch mispredict and signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand width and width of HI and LO. It must be even and ≥ 4.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the unit can accept; equals (state == IDLE) && !flush.
- `req_op` in 3: `MD_OP` code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `req_a` in WIDTH: operand a (rs); dividend for DIV/DIVU; the source value for MTHI/MTLO.
- `req_b` in WIDTH: operand b (rt); divisor for DIV/DIVU.
- `flush` in 1: abort any in-flight operation and block acceptance this cycle.
- `busy` out 1: high in the MUL and DIV states.
- `done` out 1: one-cycle pulse in the cycle new HI/LO values first become visible.
- `hi` out WIDTH: architectural HI register.
- `lo` out WIDTH: architectural LO register.

## Operation
- **Accept:** a request is accepted at a rising edge where `req_valid && req_ready`. Signs of a and b are captured, and the magnitudes |a| and |b| are captured for signed ops. Unsigned ops use the raw values.
- **MTHI/MTLO:** written at the accept edge; `done` is set at the same edge. The state stays IDLE, so back-to-back issue is allowed.
- **MULT/MULTU:** the result is the 2·WIDTH product. HI = upper WIDTH bits, LO = lower WIDTH bits. For signed ops the product is negated when sa^sb.
- **DIV/DIVU:** restoring division on magnitudes.
  - LO = quotient, negated when sa^sb.
  - HI = remainder, negated when sa.
- **Divide by zero:** LO = all ones, HI = a (raw). Completes at the first edge after accept.
- **Signed overflow (MIN / −1):** LO = MIN (0x8000_0000 at WIDTH = 32), HI = 0. This falls out of the magnitude arithmetic plus truncation; no special case is needed.
- **States:**
  - IDLE → MUL on an accepted MULT/MULTU.
  - IDLE → DIV on an accepted DIV/DIVU.
  - MUL/DIV → IDLE after the final iteration (HI/LO written, `done` set), or on `flush`.
- **Sign fixup:** applied combinationally on the write edge; there is no extra state.
- **Iteration counter:** `$clog2(WIDTH)+1` bits. It is cleared on accept and increments once per iteration edge.
- **Flush:** while in MUL/DIV, the unit returns to IDLE at the next edge with no HI/LO write and no `done`.
  - If flush coincides with the final-iteration edge, flush wins and nothing is written.
  - If flush coincides with `req_valid` in IDLE, the request is not accepted, including MTHI/MTLO.
- **Outputs not driven from a register:** `req_ready` and `busy` are derived from state.

## Timing
- **Reset:** state = IDLE, `hi` = 0, `lo` = 0, `done` = 0, counter = 0, so `busy` = 0 and `req_ready` = !flush.
- **MTHI/MTLO latency:** accept at edge E; `hi`/`lo` and `done` are visible in the cycle after E.
- **DIV/DIVU latency:** WIDTH iteration edges after the accept edge. HI/LO are written at edge E+WIDTH; `done` is visible during cycle E+WIDTH. For WIDTH = 32 that is 32 cycles of `busy`.
- **MULT/MULTU latency:** without `MULDIV_FAST_MUL_EN`, the same as DIV (WIDTH-cycle shift-add). With the macro, see Configuration.
- **`done` width:** exactly one cycle; it is cleared at the next edge unless another completion occurs.
- **Back-to-back:** `req_ready` rises in the same cycle `done` is high, so a new request may be accepted at the edge ending the `done` cycle.
- **Reset mid-operation:** the in-flight op is discarded and HI/LO are cleared to 0.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:** multiply uses a single-cycle WIDTH×WIDTH array product registered once. MUL lasts one cycle; HI/LO are written at edge E+1. Divide is unaffected.
- **`MULDIV_FAST_MUL_EN` undefined:** radix-2 shift-add multiply, WIDTH iterations, with no hardware multiplier inferred.

## Structure
- **Shared `defines.svh`:**
  - `MD_OP` enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are ignored when accepted and do not complete.
  - `MD_STATE` enum: IDLE, MUL, DIV.
- **Sub-module `div_step`:** combinational single restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and used each DIV iteration.
- **Top level:** FSM, counter, operand/sign registers, multiply datapath, HI/LO registers.

## Test plan
- **Reset:** assert `rst` 2 cycles → `hi` = `lo` = 0, `busy` = 0, `done` = 0, `req_ready` = 1.
- **MULT signed:** a = 0xFFFF_FFFD (−3), b = 7 → after the documented latency, `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFEB, `done` pulses one cycle. Repeat as MULTU → `hi` = 0x0000_0006, `lo` = 0xFFFF_FFEB.
- **DIV signed:** a = −7, b = 2 → exactly 32 busy cycles, then `lo` = 0xFFFF_FFFD, `hi` = 0xFFFF_FFFF.
- **DIVU with b = 0:** a = 0x1234 → `done` the cycle after accept, `lo` = 0xFFFF_FFFF, `hi` = 0x1234.
- **Overflow:** DIV a = 0x8000_0000, b = 0xFFFF_FFFF → `lo` = 0x8000_0000, `hi` = 0.
- **Flush:**
  - Flush on the 10th DIV cycle → IDLE next cycle, HI/LO unchanged, no `done`.
  - Flush coincident with an MTHI request → not accepted, `hi` unchanged.
  - MTLO immediately after → accepted, `lo` updated the next cycle.
